// File: rtl/clk_period_meter_pkg.sv
// rtl/clk_period_meter_pkg.sv - shared constants and state type for the period meter
package clk_period_meter_pkg;

  localparam int DEF_CNT_W      = 32;
  // Nominal divider tick period; the meter accepts up to twice that before timing out.
  localparam int NOMINAL_PERIOD = 200000;
  localparam int DEF_TIMEOUT    = 2 * NOMINAL_PERIOD;

  typedef enum logic {
    IDLE,
    MEASURE
  } meter_state_e;

endpackage

// File: rtl/clk_period_meter_if.sv
// rtl/clk_period_meter_if.sv - measured waveform input and measurement result bundle
interface clk_period_meter_if
  import clk_period_meter_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic             sig_in;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             valid;
  logic             locked;
  logic             timeout;

  modport master (
    input  sig_in,
    output period_out,
    output high_out,
    output valid,
    output locked,
    output timeout
  );

  modport slave (
    output sig_in,
    input  period_out,
    input  high_out,
    input  valid,
    input  locked,
    input  timeout
  );

endinterface

// File: rtl/clk_period_meter_sync_edge_det.sv
// rtl/clk_period_meter_sync_edge_det.sv - synchronizer chain plus history flop giving rise/fall strobes
module clk_period_meter_sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
      hist   <= sync_q[SYNC_STAGES-1];
    end
  end

  // Both strobes come off the same flop pair, so rise and fall see identical latency.
  assign rise = sync_q[SYNC_STAGES-1] & ~hist;
  assign fall = ~sync_q[SYNC_STAGES-1] & hist;

endmodule

// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - measures period and high time of a slow square wave in clk cycles
module clk_period_meter
  import clk_period_meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  clk_period_meter_if.master  mif
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic             rise;
  logic             fall;
  meter_state_e     state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] high_reg;
  logic             high_seen;

  clk_period_meter_sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .clk  (clk),
    .rst  (rst),
    .sig  (mif.sig_in),
    .rise (rise),
    .fall (fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      high_reg       <= '0;
      high_seen      <= 1'b0;
      mif.period_out <= '0;
      mif.high_out   <= '0;
      mif.valid      <= 1'b0;
      mif.locked     <= 1'b0;
      mif.timeout    <= 1'b0;
    end else begin
      mif.valid <= 1'b0;
      case (state)
        IDLE: begin
          // The partial cycle before the first rise is never measured.
          cnt <= '0;
          if (rise) begin
            high_seen <= 1'b0;
            state     <= MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            mif.period_out <= cnt + ONE;
            mif.high_out   <= high_reg;
            mif.valid      <= 1'b1;
            mif.locked     <= 1'b1;
            mif.timeout    <= 1'b0;
            cnt            <= '0;
            high_seen      <= 1'b0;
          end else if (cnt == LAST_CNT) begin
            mif.timeout <= 1'b1;
            mif.locked  <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + ONE;
            if (fall && !high_seen) begin
              high_reg  <= cnt + ONE;
              high_seen <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// tb/tb_clk_period_meter.sv - randomized self-checking bench for clk_period_meter
module tb_clk_period_meter;

  localparam int TO = 64;
  localparam int SS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  clk_period_meter_if #(.CNT_W(32)) sif ();
  clk_period_meter_if #(.CNT_W(32)) dif ();

  clk_period_meter #(
    .CNT_W(32), .TIMEOUT(TO), .SYNC_STAGES(SS)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .mif (sif.master)
  );

  clk_period_meter u_dut_def (
    .clk (clk),
    .rst (rst),
    .mif (dif.master)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: timestamps of edges as seen after the synchronizer delay.
  int          cyc = 0;
  bit          smp[$];
  int          rise_t, fall_t;
  bit          armed, fall_seen;
  logic [31:0] e_period, e_high;
  bit          e_valid, e_locked, e_timeout;
  int          nvalid = 0;
  logic [31:0] cap_p = 0, cap_h = 0;

  always @(posedge clk) begin
    bit r, f;
    cyc++;
    if (rst) begin
      smp = {};
      repeat (SS + 2) smp.push_back(1'b0);
      armed = 0; fall_seen = 0; rise_t = 0; fall_t = 0;
      e_period = 0; e_high = 0; e_valid = 0; e_locked = 0; e_timeout = 0;
    end else begin
      smp.push_front(sif.sig_in);
      void'(smp.pop_back());
      r = smp[SS] && !smp[SS+1];
      f = !smp[SS] && smp[SS+1];
      e_valid = 0;
      if (r) begin
        if (armed) begin
          e_period  = cyc - rise_t;
          if (fall_seen) e_high = fall_t - rise_t;
          e_valid   = 1;
          e_locked  = 1;
          e_timeout = 0;
        end
        armed = 1; rise_t = cyc; fall_seen = 0;
      end else if (armed && (cyc - rise_t) == TO) begin
        e_timeout = 1; e_locked = 0; armed = 0;
      end else if (armed && f && !fall_seen) begin
        fall_t = cyc; fall_seen = 1;
      end
      #1;
      check_val("cyc_valid",   {31'd0, sif.valid},   {31'd0, e_valid});
      check_val("cyc_locked",  {31'd0, sif.locked},  {31'd0, e_locked});
      check_val("cyc_timeout", {31'd0, sif.timeout}, {31'd0, e_timeout});
      check_val("cyc_period",  sif.period_out, e_period);
      check_val("cyc_high",    sif.high_out,   e_high);
      if (sif.valid) begin
        nvalid++;
        cap_p = sif.period_out;
        cap_h = sif.high_out;
      end
    end
  end

  task automatic drive_wave(input int per, input int hi, input int n, input bit to_def);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < per; i++) begin
        @(negedge clk);
        if (to_def) dif.sig_in = (i < hi);
        else        sif.sig_in = (i < hi);
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int v0;
    int per, hi;
    sif.sig_in = 1'b0;
    dif.sig_in = 1'b0;
    rst = 1'b1;
    idle_cycles(3);
    check_val("rst_period",  sif.period_out, 0);
    check_val("rst_high",    sif.high_out, 0);
    check_val("rst_valid",   {31'd0, sif.valid}, 0);
    check_val("rst_locked",  {31'd0, sif.locked}, 0);
    check_val("rst_timeout", {31'd0, sif.timeout}, 0);
    rst = 1'b0;

    v0 = nvalid;
    drive_wave(20, 8, 5, 0);
    check_val("p20_count",   nvalid - v0, 4);
    check_val("p20_period",  cap_p, 20);
    check_val("p20_high",    cap_h, 8);
    check_val("p20_locked",  {31'd0, sif.locked}, 1);
    check_val("p20_timeout", {31'd0, sif.timeout}, 0);

    drive_wave(12, 6, 4, 0);
    check_val("p12_period", cap_p, 12);
    check_val("p12_high",   cap_h, 6);

    idle_cycles(80);
    check_val("stuck_timeout", {31'd0, sif.timeout}, 1);
    check_val("stuck_locked",  {31'd0, sif.locked}, 0);
    check_val("stuck_period",  sif.period_out, 12);
    check_val("stuck_high",    sif.high_out, 6);

    v0 = nvalid;
    drive_wave(16, 5, 3, 0);
    check_val("rearm_count",   nvalid - v0, 2);
    check_val("rearm_timeout", {31'd0, sif.timeout}, 0);
    check_val("rearm_period",  cap_p, 16);

    drive_wave(64, 32, 3, 0);
    check_val("p64_period",  cap_p, 64);
    check_val("p64_high",    cap_h, 32);
    check_val("p64_timeout", {31'd0, sif.timeout}, 0);

    drive_wave(65, 30, 2, 0);
    idle_cycles(80);
    check_val("p65_timeout", {31'd0, sif.timeout}, 1);
    check_val("p65_period",  sif.period_out, 64);

    for (int k = 0; k < 30; k++) begin
      per = $urandom_range(70, 2);
      hi  = $urandom_range(per - 1, 1);
      drive_wave(per, hi, 1, 0);
    end
    idle_cycles(80);

    drive_wave(10, 4, 3, 0);
    @(negedge clk);
    sif.sig_in = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("arst_period", sif.period_out, 0);
    check_val("arst_high",   sif.high_out, 0);
    check_val("arst_locked", {31'd0, sif.locked}, 0);
    check_val("arst_valid",  {31'd0, sif.valid}, 0);
    @(negedge clk);
    sif.sig_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(2);
    check_val("post_rst_locked", {31'd0, sif.locked}, 0);
    v0 = nvalid;
    drive_wave(10, 4, 3, 0);
    check_val("post_rst_count",  nvalid - v0, 2);
    check_val("post_rst_period", cap_p, 10);
    check_val("post_rst_high",   cap_h, 4);

    drive_wave(2000, 1000, 3, 1);
    idle_cycles(5);
    check_val("def_period",  dif.period_out, 2000);
    check_val("def_high",    dif.high_out, 1000);
    check_val("def_locked",  {31'd0, dif.locked}, 1);
    check_val("def_timeout", {31'd0, dif.timeout}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
